// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller: scoreboard entry,
// forward-select encoding and the operand match rule.
package pipe_hazard_ctrl_pkg;

  localparam int DEPTH_DEF      = 3;
  localparam int LOAD_STAGE_DEF = 2;
  localparam int MD_LAT_DEF     = 8;

  localparam int RDY_W    = 3;  // holds a stage number up to 6
  localparam int MD_CNT_W = 6;  // holds a latency up to 32
  localparam int SEL_RF   = 0;  // forward select: take the register file

  typedef struct packed {
    logic             valid;
    logic [4:0]       dst;
    logic             regwrite;
    logic [RDY_W-1:0] rdy;      // first stage whose end makes the result forwardable
  } entry_t;

  function automatic logic entry_match(input entry_t e, input logic [4:0] r);
    return e.valid && e.regwrite && (e.dst == r) && (r != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority match of one source operand against the in-flight producers: picks the
// youngest producer for forwarding and flags a producer that is not ready in time.
module hazard_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int FSW   = $clog2(DEPTH + 1),
  parameter int MIN_K = 1
) (
  input  entry_t         ent_i [1:DEPTH],
  input  logic [4:0]     reg_i,
  input  logic           used_i,
  input  logic           need_now_i,  // operand consumed in this stage rather than the next
  output logic [FSW-1:0] sel_o,
  output logic           stall_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    sel_o   = FSW'(SEL_RF);
    stall_o = 1'b0;
    // Scan oldest to youngest so the youngest match overwrites the select last.
    for (int k = DEPTH; k >= MIN_K; k--) begin
      if (entry_match(ent_i[k], reg_i)) begin
        sel_o = (k > int'(ent_i[k].rdy)) ? FSW'(k - 1) : FSW'(SEL_RF);
        if (used_i && ((need_now_i ? k : k + 1) <= int'(ent_i[k].rdy))) stall_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight writers, resolves ID/EX forwarding,
// stalls ID on late data or a busy multiply/divide unit, and flushes IF/ID on taken branches.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LOAD_STAGE = LOAD_STAGE_DEF,
  parameter int MD_LAT     = MD_LAT_DEF,
  parameter int FSW        = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [4:0]     id_rs,
  input  logic [4:0]     id_rt,
  input  logic           id_rs_used,
  input  logic           id_rt_used,
  input  logic [4:0]     id_dst,
  input  logic           id_regwrite,
  input  logic           id_load,
  input  logic           id_branch,
  input  logic           branch_taken,
  input  logic           id_md_start,
  input  logic           id_md_read,
  output logic           pc_en,
  output logic           ifid_en,
  output logic           ifid_flush,
  output logic           idex_bubble,
  output logic [FSW-1:0] fwd_rs_id,
  output logic [FSW-1:0] fwd_rt_id,
  output logic [FSW-1:0] fwd_rs_ex,
  output logic [FSW-1:0] fwd_rt_ex,
  output logic           md_busy,
  output logic [15:0]    stall_cnt
);

  entry_t              ent_q [1:DEPTH];
  entry_t              ent_d;
  logic [4:0]          ex_rs_q, ex_rt_q;
  logic                ex_rs_used_q, ex_rt_used_q;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;
  logic                rs_id_stall, rt_id_stall, rs_ex_late, rt_ex_late;
  logic                stall, issue;

  hazard_match #(.DEPTH(DEPTH), .FSW(FSW), .MIN_K(1)) u_rs_id (
    .ent_i(ent_q), .reg_i(id_rs), .used_i(id_rs_used), .need_now_i(id_branch),
    .sel_o(fwd_rs_id), .stall_o(rs_id_stall));
  hazard_match #(.DEPTH(DEPTH), .FSW(FSW), .MIN_K(1)) u_rt_id (
    .ent_i(ent_q), .reg_i(id_rt), .used_i(id_rt_used), .need_now_i(id_branch),
    .sel_o(fwd_rt_id), .stall_o(rt_id_stall));
  hazard_match #(.DEPTH(DEPTH), .FSW(FSW), .MIN_K(2)) u_rs_ex (
    .ent_i(ent_q), .reg_i(ex_rs_q), .used_i(ex_rs_used_q), .need_now_i(1'b1),
    .sel_o(fwd_rs_ex), .stall_o(rs_ex_late));
  hazard_match #(.DEPTH(DEPTH), .FSW(FSW), .MIN_K(2)) u_rt_ex (
    .ent_i(ent_q), .reg_i(ex_rt_q), .used_i(ex_rt_used_q), .need_now_i(1'b1),
    .sel_o(fwd_rt_ex), .stall_o(rt_ex_late));

  assign md_busy     = (md_cnt_q != '0);
  // The rst term keeps the control outputs benign while reset is held.
  assign stall       = rst & id_valid & (rs_id_stall | rt_id_stall |
                                         (md_busy & (id_md_read | id_md_start)));
  assign issue       = id_valid & ~stall;
  assign pc_en       = ~stall;
  assign ifid_en     = ~stall;
  assign idex_bubble = stall;
  assign ifid_flush  = rst & branch_taken & ~stall;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    ent_d          = '0;
    ent_d.valid    = issue;
    ent_d.dst      = id_dst;
    ent_d.regwrite = id_regwrite;
    ent_d.rdy      = id_load ? RDY_W'(LOAD_STAGE) : RDY_W'(1);

    md_cnt_d = md_cnt_q;
    if (id_md_start && !stall) md_cnt_d = MD_CNT_W'(MD_LAT);
    else if (md_busy)          md_cnt_d = md_cnt_q - 1'b1;

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the scoreboard is reset, not left to power-up, so no stale producer can force a stall.
      for (int k = 1; k <= DEPTH; k++) ent_q[k] <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rs_used_q <= 1'b0;
      ex_rt_used_q <= 1'b0;
      md_cnt_q     <= '0;
      stall_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking updates let the shift read every old stage before any is overwritten.
      ent_q[1] <= ent_d;
      for (int k = 2; k <= DEPTH; k++) ent_q[k] <= ent_q[k-1];
      ex_rs_q      <= issue ? id_rs : 5'd0;
      ex_rt_q      <= issue ? id_rt : 5'd0;
      ex_rs_used_q <= issue & id_rs_used;
      ex_rt_used_q <= issue & id_rt_used;
      md_cnt_q     <= md_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // An instruction admitted to EX must never find its producer still unready.
  a_ex_ready : assert property (@(posedge clk) disable iff (!rst) !(rs_ex_late | rt_ex_late));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters; expected values are hand-derived.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used, id_regwrite, id_load, id_branch;
  logic        branch_taken, id_md_start, id_md_read;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, md_busy;
  logic [1:0]  fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_load(id_load), .id_branch(id_branch),
    .branch_taken(branch_taken), .id_md_start(id_md_start), .id_md_read(id_md_read),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_rs_id(fwd_rs_id), .fwd_rt_id(fwd_rt_id), .fwd_rs_ex(fwd_rs_ex),
    .fwd_rt_ex(fwd_rt_ex), .md_busy(md_busy), .stall_cnt(stall_cnt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_dst = 0; id_regwrite = 0; id_load = 0; id_branch = 0;
    branch_taken = 0; id_md_start = 0; id_md_read = 0;
  endtask

  task automatic op(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                    input logic rtu, input logic [4:0] dst, input logic wr,
                    input logic ld, input logic br);
    idle();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_dst = dst; id_regwrite = wr; id_load = ld; id_branch = br;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) next_cycle();
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, ".pc_en"}, pc_en, !exp);
    check({tag, ".ifid_en"}, ifid_en, !exp);
    check({tag, ".bubble"}, idex_bubble, exp);
  endtask

  initial begin
    rst = 0;
    op(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 1);
    branch_taken = 1;
    repeat (2) @(negedge clk);
    check_stall("reset", 0);
    check("reset.flush", ifid_flush, 0);
    check("reset.sel", {fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex}, 0);
    check("reset.md_busy", md_busy, 0);
    check("reset.stall_cnt", stall_cnt, 0);
    idle();
    rst = 1;
    next_cycle();

    // add $3,$1,$2 ; sub $4,$3,$1
    op(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    @(negedge clk); check_stall("add", 0);
    next_cycle();
    op(5'd3, 5'd1, 1, 1, 5'd4, 1, 0, 0);
    @(negedge clk); check_stall("sub", 0);
    check("sub.fwd_rs_id", fwd_rs_id, 0);
    next_cycle(); idle();
    @(negedge clk);
    check("sub.fwd_rs_ex", fwd_rs_ex, 1);
    check("sub.fwd_rt_ex", fwd_rt_ex, 0);
    drain();

    // lw $5,0($0) ; add $6,$5,$5
    op(5'd0, 5'd0, 1, 0, 5'd5, 1, 1, 0);
    @(negedge clk); check_stall("lw", 0);
    next_cycle();
    op(5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 0);
    @(negedge clk); check_stall("lu.stall1", 1);
    next_cycle();
    @(negedge clk); check_stall("lu.go", 0);
    next_cycle(); idle();
    @(negedge clk);
    check("lu.fwd_rs_ex", fwd_rs_ex, 2);
    check("lu.fwd_rt_ex", fwd_rt_ex, 2);
    drain();

    // lw $7 ; beq $7,$0 taken: two stalls, flush only once released
    op(5'd0, 5'd0, 1, 0, 5'd7, 1, 1, 0);
    next_cycle();
    op(5'd7, 5'd0, 1, 1, 5'd0, 0, 0, 1);
    branch_taken = 1;
    @(negedge clk); check_stall("lbr.stall1", 1); check("lbr.flush1", ifid_flush, 0);
    next_cycle();
    @(negedge clk); check_stall("lbr.stall2", 1); check("lbr.flush2", ifid_flush, 0);
    next_cycle();
    @(negedge clk); check_stall("lbr.go", 0); check("lbr.flush3", ifid_flush, 1);
    check("lbr.fwd_rs_id", fwd_rs_id, 2);
    check("lbr.fwd_rt_id", fwd_rt_id, 0);
    next_cycle(); idle();
    @(negedge clk); check("lbr.flush_end", ifid_flush, 0);
    drain();

    // add $7 ; beq $7,$0: one stall then forward from MEM
    op(5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0);
    next_cycle();
    op(5'd7, 5'd0, 1, 1, 5'd0, 0, 0, 1);
    @(negedge clk); check_stall("abr.stall1", 1);
    next_cycle();
    @(negedge clk); check_stall("abr.go", 0);
    check("abr.fwd_rs_id", fwd_rs_id, 1);
    drain();

    // taken branch without hazard
    op(5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 1);
    branch_taken = 1;
    @(negedge clk); check_stall("br", 0); check("br.flush", ifid_flush, 1);
    next_cycle(); idle();
    @(negedge clk); check("br.flush_end", ifid_flush, 0);
    drain();

    // write $0 then read $0
    op(5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0);
    next_cycle();
    op(5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 1);
    @(negedge clk); check_stall("r0", 0);
    check("r0.fwd_id", {fwd_rs_id, fwd_rt_id}, 0);
    next_cycle(); idle();
    @(negedge clk); check("r0.fwd_ex", {fwd_rs_ex, fwd_rt_ex}, 0);
    check("cum.stall_cnt", stall_cnt, 4);
    drain();

    // asynchronous reset clears the stall counter
    @(negedge clk); rst = 0; #1;
    check("rst.stall_cnt", stall_cnt, 0);
    rst = 1;
    next_cycle();

    // mult ; gap ; mflo: busy 8 cycles, 7 stalls
    op(5'd8, 5'd9, 1, 1, 5'd0, 0, 0, 0);
    id_md_start = 1;
    @(negedge clk); check("md.busy0", md_busy, 0); check_stall("md.start", 0);
    next_cycle(); idle();
    @(negedge clk); check("md.busy1", md_busy, 1); check_stall("md.gap", 0);
    next_cycle();
    op(5'd0, 5'd0, 0, 0, 5'd10, 1, 0, 0);
    id_md_read = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("md.busy_s%0d", i), md_busy, 1);
      check($sformatf("md.stall_s%0d", i), pc_en, 0);
      next_cycle();
    end
    @(negedge clk);
    check("md.done", md_busy, 0);
    check_stall("md.mflo_go", 0);
    check("md.stall_cnt", stall_cnt, 7);
    drain();

    // reset pulse in the middle of an MD stall
    op(5'd8, 5'd9, 1, 1, 5'd0, 0, 0, 0);
    id_md_start = 1;
    next_cycle();
    op(5'd0, 5'd0, 0, 0, 5'd10, 1, 0, 0);
    id_md_read = 1;
    @(negedge clk); check("mdr.stall", pc_en, 0);
    rst = 0; #1;
    check("mdr.busy_rst", md_busy, 0);
    check_stall("mdr.in_rst", 0);
    #1 rst = 1;
    next_cycle();
    @(negedge clk);
    check_stall("mdr.after", 0);
    check("mdr.busy_after", md_busy, 0);
    check("mdr.stall_cnt", stall_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter DEPTH, default 3, number of tracked stages after decode (stage 1=EX, 2=MEM, 3=WB; legal range 3..6).
REQ-002 Parameter LOAD_STAGE, default 2, the stage at whose end load data becomes forwardable (legal range 2..DEPTH-1).
REQ-003 Parameter MD_LAT, default 8, cycle count of the multi-cycle multiply/divide unit (legal range 2..32).
REQ-004 Parameter FSW = clog2(DEPTH+1), the width of each forward select.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_rs, id_rt  in  5 each  ID source register numbers.
REQ-009 id_rs_used, id_rt_used  in  1 each  the instruction reads the source.
REQ-010 id_dst, id_regwrite, id_load  in  5/1/1  destination, writes the GPR, is a load.
REQ-011 id_branch  in  1  branch or jr resolved in ID, which needs its operands in ID.
REQ-012 branch_taken  in  1  the ID redirect is taken this cycle.
REQ-013 id_md_start, id_md_read  in  1 each  starts a mult/div; reads HI/LO.
REQ-014 pc_en, ifid_en  out  1 each  PC and IF/ID write enables.
REQ-015 ifid_flush  out  1  clears IF/ID to a nop.
REQ-016 idex_bubble  out  1  loads a nop into ID/EX.
REQ-017 fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex  out  FSW each  0 = register file, k = stage k+1 result.
REQ-018 md_busy  out  1  mult/div in progress.
REQ-019 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-020 The block SHALL hold a tracking entry per stage 1..DEPTH: {valid, dst, regwrite, rdy}, where rdy = LOAD_STAGE for loads and 1 otherwise.
REQ-021 Every cycle entries SHALL shift k to k+1; the stage-DEPTH entry is discarded.
REQ-022 Stage 1 SHALL load the ID instruction when stall=0 and id_valid=1, and SHALL load valid=0 otherwise.
REQ-023 An entry SHALL match operand r when valid & regwrite & dst==r & r!=0.
REQ-024 EX hazard: a match at stage k>=2 SHALL drive the EX select to k-1 when k>rdy; the youngest (lowest k) match wins; with no match the select is 0.
REQ-025 ID hazard for a used operand: a match at stage k SHALL stall when k+1<=rdy (non-branch) or k<=rdy (id_branch=1).
REQ-026 The ID selects SHALL use the same priority and SHALL select stage k only when k>rdy.
REQ-027 MD stall SHALL assert when md_busy & (id_md_read | id_md_start).
REQ-028 stall SHALL equal id_valid & (ID hazard | MD stall), and SHALL be combinational in the same cycle.
REQ-029 stall=1 SHALL give pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0.
REQ-030 branch_taken & ~stall SHALL give ifid_flush=1 for exactly that cycle; stall takes precedence over flush.
REQ-031 id_md_start & ~stall SHALL load the MD counter with MD_LAT.
REQ-032 The MD counter SHALL decrement to 0; md_busy = (counter != 0).
REQ-033 stall_cnt SHALL increment on each stall cycle and SHALL hold at 16'hFFFF.

Reset
REQ-034 rst=0 SHALL, asynchronously, clear all entries, the MD counter, and stall_cnt.
REQ-035 While in reset, outputs SHALL be pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, all selects 0, md_busy=0.
REQ-036 Reset asserted mid-stall or mid-MD SHALL abandon that operation with no residual stall after release.

Structure
REQ-037 A shared package SHALL hold the entry struct type, the select encodings (SEL_RF=0), and the parameter defaults.
REQ-038 One sub-module, hazard_match, SHALL resolve the priority match for one operand and SHALL be instanced four times.

Verification
REQ-039 add $3,$1,$2; sub $4,$3,$1 -> fwd_rs_ex=1 in the sub's EX cycle, no stall.
REQ-040 lw $5,0($0); add $6,$5,$5 -> exactly 1 stall cycle (pc_en=0, idex_bubble=1), then fwd_rs_ex=fwd_rt_ex=2.
REQ-041 lw $7; beq $7,$0 -> 2 stall cycles, then fwd_rs_id=2; add $7; beq $7 -> 1 stall cycle, then fwd_rs_id=1.
REQ-042 Taken branch with no hazard -> ifid_flush=1 for 1 cycle; with a hazard -> flush only in the first non-stall cycle.
REQ-043 mult, then mflo 1 cycle later with MD_LAT=8 -> md_busy high 8 cycles, 7 stall cycles, stall_cnt=7.
REQ-044 Write to $0 followed by a read of $0 -> selects 0, no stall; rst pulse during an MD op -> md_busy=0 immediately.
